// File: rtl/addac_pkg.sv
// rtl/addac_pkg.sv - shared types and constants for the addac serial adder slice
package addac_pkg;

    // Default serial word length, shared with the adder-side driver and benches.
    localparam int ADDAC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } addac_sipo_state_t;

endpackage

// File: rtl/addac_bit_counter.sv
// rtl/addac_bit_counter.sv - bit position counter with clear, enable and last-bit flag
module addac_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] count;

    // Clear wins over enable so an abort in the same cycle as a bit drops that bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/addac_sipo.sv
// rtl/addac_sipo.sv - serial-in/parallel-out collector for the addac sum/carry stream
module addac_sipo
    import addac_pkg::*;
#(
    parameter int WIDTH = ADDAC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             s_in,
    input  logic             cout_in,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             overrun
);

    addac_sipo_state_t state;
    logic [WIDTH-1:0]  shreg;
    logic              bit_last;
    logic              take_bit;
    logic              final_bit;
    logic              accept;
    logic              restart;
    logic              cnt_clr;
    logic              cnt_en;

    always_comb begin
        take_bit  = (state == COLLECT) && bit_valid && !start;
        final_bit = take_bit && bit_last;
        accept    = (state == HOLD) && result_ready;
        restart   = start && ((state == IDLE) || (state == COLLECT) || accept);
        // Clearing on the final bit keeps the counter from ever wrapping.
        cnt_clr   = restart || final_bit;
        cnt_en    = take_bit;
    end

    addac_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (bit_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            carry        <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= COLLECT;
                        shreg   <= '0;
                        overrun <= 1'b0;
                        busy    <= 1'b1;
                    end else if (bit_valid) begin
                        overrun <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (start) begin
                        shreg <= '0;
                    end else if (bit_valid) begin
                        shreg <= {s_in, shreg[WIDTH-1:1]};
                        if (bit_last) begin
                            carry        <= cout_in;
                            state        <= HOLD;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (result_ready && start) begin
                        state        <= COLLECT;
                        shreg        <= '0;
                        overrun      <= 1'b0;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                    end else begin
                        if (result_ready) begin
                            state        <= IDLE;
                            result_valid <= 1'b0;
                        end
                        if (bit_valid) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

    assign result = shreg;

endmodule

// File: tb/tb_addac_sipo.sv
// tb/tb_addac_sipo.sv - directed self-checking bench for addac_sipo
module tb_addac_sipo;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       bit_valid;
    logic       s_in;
    logic       cout_in;
    logic [7:0] result;
    logic       carry;
    logic       result_valid;
    logic       result_ready;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addac_sipo #(
        .WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bit_valid    (bit_valid),
        .s_in         (s_in),
        .cout_in      (cout_in),
        .result       (result),
        .carry        (carry),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic c, input int gap);
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1;
            s_in      = w[i];
            cout_in   = (i == 7) ? c : 1'b0;
            tick();
            bit_valid = 1'b0;
            s_in      = 1'b0;
            cout_in   = 1'b0;
            if (i < 7) begin
                chk("busy_mid", {31'd0, busy}, 32'd1);
                chk("rv_mid", {31'd0, result_valid}, 32'd0);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("busy_gap", {31'd0, busy}, 32'd1);
                end
            end
        end
        chk("rv_rise", {31'd0, result_valid}, 32'd1);
        chk("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bit_valid    = 1'b0;
        s_in         = 1'b0;
        cout_in      = 1'b0;
        result_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_result", {24'd0, result}, 32'h00);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        chk("rst_rv", {31'd0, result_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);

        // Word A5 on consecutive cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        send_word(8'hA5, 1'b1, 0);
        chk("a5_result", {24'd0, result}, 32'hA5);
        chk("a5_carry", {31'd0, carry}, 32'd1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("a5_rv_drop", {31'd0, result_valid}, 32'd0);
        chk("a5_idle_busy", {31'd0, busy}, 32'd0);

        // Same word with 3-cycle gaps
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(8'hA5, 1'b1, 3);
        chk("gap_result", {24'd0, result}, 32'hA5);
        chk("gap_carry", {31'd0, carry}, 32'd1);
        chk("gap_overrun", {31'd0, overrun}, 32'd0);

        // Hold with ready low for 5 cycles and a stray bit; start ignored without ready
        for (int k = 0; k < 5; k++) begin
            bit_valid = (k == 1);
            s_in      = 1'b0;
            start     = (k == 3);
            tick();
            bit_valid = 1'b0;
            start     = 1'b0;
            chk("hold_result", {24'd0, result}, 32'hA5);
            chk("hold_rv", {31'd0, result_valid}, 32'd1);
            chk("hold_busy", {31'd0, busy}, 32'd0);
        end
        chk("hold_overrun", {31'd0, overrun}, 32'd1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("hold_rv_drop", {31'd0, result_valid}, 32'd0);
        chk("hold_overrun_sticky", {31'd0, overrun}, 32'd1);

        // Start with a simultaneous bit clears overrun and discards the bit
        start     = 1'b1;
        bit_valid = 1'b1;
        s_in      = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        chk("start_clr_overrun", {31'd0, overrun}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            bit_valid = 1'b1;
            s_in      = 1'b1;
            cout_in   = 1'b1;
            tick();
        end
        // Abort with a bit in the same cycle, then a fresh 3C word
        start = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        cout_in   = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd1);
        chk("abort_overrun", {31'd0, overrun}, 32'd0);
        send_word(8'h3C, 1'b0, 0);
        chk("3c_result", {24'd0, result}, 32'h3C);
        chk("3c_carry", {31'd0, carry}, 32'd0);

        // Back-to-back: handshake and start together, then FF
        result_ready = 1'b1;
        start        = 1'b1;
        tick();
        result_ready = 1'b0;
        start        = 1'b0;
        chk("b2b_rv", {31'd0, result_valid}, 32'd0);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        send_word(8'hFF, 1'b1, 0);
        chk("ff_result", {24'd0, result}, 32'hFF);
        chk("ff_carry", {31'd0, carry}, 32'd1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;

        // Bit in IDLE without start sets overrun
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        chk("idle_overrun", {31'd0, overrun}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset after 5 bits
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bit_valid = 1'b1;
            s_in      = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_result", {24'd0, result}, 32'h00);
        chk("arst_carry", {31'd0, carry}, 32'd0);
        chk("arst_rv", {31'd0, result_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_overrun", {31'd0, overrun}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(8'h01, 1'b0, 0);
        chk("01_result", {24'd0, result}, 32'h01);
        chk("01_carry", {31'd0, carry}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addac_sipo.md
# addac_sipo

Serial-in/parallel-out collector placed directly downstream of the serial adder/accumulator (`addac`). It samples the adder's serial sum bit `s` LSB-first, one qualified bit per cycle, into a WIDTH-bit word. It latches the adder's `cout` on the final bit, then presents word and carry on a valid/ready output handshake with hold-until-accepted semantics.

## Interface
- `WIDTH`, default 8: number of serial sum bits per word, minimum 2.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  begins collection of a new word; single-cycle pulse.
- `bit_valid`  input  1  `s_in`/`cout_in` carry a valid adder output this cycle.
- `s_in`  input  1  serial sum bit from the adder, LSB first.
- `cout_in`  input  1  adder carry-out; sampled only with the final bit.
- `result`  output  WIDTH  assembled sum word; `result[0]` is the first bit received.
- `carry`  output  1  carry latched with bit WIDTH-1.
- `result_valid`  output  1  `result`/`carry` are valid and held.
- `result_ready`  input  1  consumer accepts the word when `result_valid && result_ready`.
- `busy`  output  1  high while in COLLECT.
- `overrun`  output  1  sticky; a `bit_valid` arrived while not collecting.

## Operation
- States: IDLE, COLLECT, HOLD. The state encoding is a shared enum.
- IDLE:
  - `start` -> COLLECT; clears the bit counter, shift register and `overrun`.
  - `bit_valid` in IDLE without `start` sets `overrun`; the bit is discarded.
  - `bit_valid` in the same cycle as `start` is discarded and does not set `overrun`.
- COLLECT:
  - On each `bit_valid`: shift register <= {`s_in`, shreg[WIDTH-1:1]}; counter increments.
  - Cycles without `bit_valid` hold all state; gaps are unlimited.
  - When `bit_valid` arrives with counter == WIDTH-1: the final shift occurs, `carry` <= `cout_in`, and the state goes to HOLD.
  - `start` in COLLECT aborts the word: counter and shift register are cleared and the state stays COLLECT. Any `bit_valid` in that cycle is discarded.
- HOLD:
  - `result_valid`=1; `result` and `carry` are stable until accepted.
  - On handshake: -> IDLE, or -> COLLECT if `start` is high in the same cycle (restart, counter cleared).
  - `bit_valid` in HOLD sets `overrun`; the bit is discarded and `result` is unchanged.
  - `start` without `result_ready` in HOLD is ignored.
- Counter width: $clog2(WIDTH). Counter wrap is never reached, because the transition to HOLD occurs at WIDTH-1.
- `result` is driven from the shift register. Its contents are don't-care outside HOLD, but it never contains X after reset.

## Timing
- Reset values: state IDLE, `result`=0, `carry`=0, `result_valid`=0, `busy`=0, `overrun`=0, counter=0.
- Reset mid-operation: an asynchronous return to IDLE with all outputs at their reset values. A partial word is lost.
- `busy` rises on the cycle after the `start` edge.
- Latency: `result_valid` rises on the cycle after the edge that samples bit WIDTH-1.
- Back-to-back words: handshake plus `start` in the same cycle gives `result_valid` low the next cycle and `busy` high.
- All outputs are registered; there are no combinational input-to-output paths.
- `overrun` goes high on the cycle after the offending `bit_valid` and stays high until the next accepted `start` or reset.

## Structure
- Package `addac_pkg`:
  - `addac_sipo_state_t` enum (IDLE, COLLECT, HOLD).
  - `ADDAC_WIDTH` default constant, shared with the adder-side driver and benches.
- One sub-module, `addac_bit_counter`: a WIDTH-parameterised counter with clear, enable and a `last` flag at WIDTH-1.
- The FSM, shift register and output registers stay in `addac_sipo`.

## Test plan
- WIDTH=8; `start`, then bits 1,0,1,0,0,1,0,1 on consecutive cycles with `cout_in`=1 on the last bit -> `result`=8'hA5, `carry`=1, `result_valid` on the cycle after the 8th bit.
- Same word with 3-cycle `bit_valid` gaps between bits -> identical result; `busy` stays high throughout.
- `result_ready` held low for 5 cycles, with `bit_valid` pulsed in HOLD -> `result`=8'hA5 held, `overrun`=1. Raising `result_ready` -> `result_valid` drops the next cycle.
- `start`, 4 bits, `start` again, then bits for 8'h3C with `cout_in`=0 -> `result`=8'h3C, `carry`=0; the aborted bits have no effect.
- Handshake and `start` in the same cycle, then 8'hFF with `cout_in`=1 -> the second word is captured correctly with no idle cycle required.
- `rst` asserted after 5 bits -> all outputs 0 immediately. A subsequent full word (8'h01) -> `result`=8'h01.
